// File: rtl/cacheline_burst_adaptor_pkg.sv
// Shared types and constants for the cache-line to DRAM burst adaptor.
package cla_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RD_BURST,
        ST_WR_BURST,
        ST_DONE
    } cla_state_e;

    localparam int BEATS      = 4;
    localparam int BEAT_IDX_W = 2;
    localparam int OFFSET_W   = 5;

endpackage

// File: rtl/cacheline_burst_adaptor.sv
// Moves one 256-bit cache line as a 4-beat 64-bit DRAM burst.
// Optional CLA_WATCHDOG_EN aborts a stalled burst with err after TIMEOUT cycles.
module cacheline_burst_adaptor
    import cla_pkg::*;
#(
    parameter int LINE_W  = 256,
    parameter int BURST_W = 64,
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 1024
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [ADDR_W-1:0]  pmem_address,
    input  logic               pmem_read,
    input  logic               pmem_write,
    input  logic [LINE_W-1:0]  pmem_wdata,
    output logic [LINE_W-1:0]  pmem_rdata,
    output logic               pmem_resp,
    output logic               err,
    output logic [ADDR_W-1:0]  dram_address,
    output logic               dram_read,
    output logic               dram_write,
    output logic [BURST_W-1:0] dram_wdata,
    input  logic [BURST_W-1:0] dram_rdata,
    input  logic               dram_resp
);

    cla_state_e              r_state;
    logic [BEAT_IDX_W-1:0]   r_beat;
    logic [LINE_W-1:0]       r_line;
    logic [LINE_W-1:0]       r_rdata;
    logic [ADDR_W-1:0]       r_addr;
    logic                    r_dram_read;
    logic                    r_dram_write;
    logic                    r_pmem_resp;
    logic                    r_err;

    logic [LINE_W-1:0]       w_rd_line;
    logic                    w_last;
    logic                    w_expire;
    logic [ADDR_W-1:0]       w_line_addr;
    logic [OFFSET_W+31:0]    w_unused;

    assign w_last      = (r_beat == BEAT_IDX_W'(BEATS - 1));
    assign w_line_addr = {pmem_address[ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}};
    assign w_unused    = {pmem_address[OFFSET_W-1:0], 32'(TIMEOUT)};

    always_comb begin
        w_rd_line = r_line;
        w_rd_line[r_beat*BURST_W +: BURST_W] = dram_rdata;
    end

`ifdef CLA_WATCHDOG_EN
    localparam int WD_W = $clog2(TIMEOUT);

    logic [WD_W-1:0] r_wd;

    // Fires on the cycle whose increment would reach TIMEOUT-1.
    assign w_expire = !dram_resp && (r_wd == WD_W'(TIMEOUT - 2));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wd <= '0;
        end else if (r_state == ST_RD_BURST || r_state == ST_WR_BURST) begin
            r_wd <= dram_resp ? '0 : r_wd + 1'b1;
        end else begin
            r_wd <= '0;
        end
    end
`else
    assign w_expire = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_beat       <= '0;
            r_line       <= '0;
            r_rdata      <= '0;
            r_addr       <= '0;
            r_dram_read  <= 1'b0;
            r_dram_write <= 1'b0;
            r_pmem_resp  <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_pmem_resp <= 1'b0;
            r_err       <= 1'b0;
            unique case (r_state)
                ST_IDLE: begin
                    if (pmem_write) begin
                        r_addr       <= w_line_addr;
                        r_line       <= pmem_wdata;
                        r_beat       <= '0;
                        r_dram_write <= 1'b1;
                        r_state      <= ST_WR_BURST;
                    end else if (pmem_read) begin
                        r_addr      <= w_line_addr;
                        r_beat      <= '0;
                        r_dram_read <= 1'b1;
                        r_state     <= ST_RD_BURST;
                    end
                end
                ST_RD_BURST: begin
                    if (dram_resp) begin
                        r_line <= w_rd_line;
                        r_beat <= r_beat + 1'b1;
                        if (w_last) begin
                            r_rdata     <= w_rd_line;
                            r_dram_read <= 1'b0;
                            r_pmem_resp <= 1'b1;
                            r_state     <= ST_DONE;
                        end
                    end else if (w_expire) begin
                        r_dram_read <= 1'b0;
                        r_pmem_resp <= 1'b1;
                        r_err       <= 1'b1;
                        r_state     <= ST_DONE;
                    end
                end
                ST_WR_BURST: begin
                    if (dram_resp) begin
                        r_beat <= r_beat + 1'b1;
                        if (w_last) begin
                            r_dram_write <= 1'b0;
                            r_pmem_resp  <= 1'b1;
                            r_state      <= ST_DONE;
                        end
                    end else if (w_expire) begin
                        r_dram_write <= 1'b0;
                        r_pmem_resp  <= 1'b1;
                        r_err        <= 1'b1;
                        r_state      <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign pmem_rdata   = r_rdata;
    assign pmem_resp    = r_pmem_resp;
    assign err          = r_err;
    assign dram_address = r_addr;
    assign dram_read    = r_dram_read;
    assign dram_write   = r_dram_write;
    assign dram_wdata   = r_dram_write ? r_line[r_beat*BURST_W +: BURST_W]
                                       : '0;

endmodule

// File: tb/tb_cacheline_burst_adaptor.sv
// Directed bench for cacheline_burst_adaptor.
// Watchdog expectations follow CLA_WATCHDOG_EN.
module tb_cacheline_burst_adaptor;

    logic         clk;
    logic         rst_n;
    logic [31:0]  pmem_address;
    logic         pmem_read;
    logic         pmem_write;
    logic [255:0] pmem_wdata;
    logic [255:0] pmem_rdata;
    logic         pmem_resp;
    logic         err;
    logic [31:0]  dram_address;
    logic         dram_read;
    logic         dram_write;
    logic [63:0]  dram_wdata;
    logic [63:0]  dram_rdata;
    logic         dram_resp;

    int n_tests = 0;
    int n_fail  = 0;

    cacheline_burst_adaptor #(
        .LINE_W  (256),
        .BURST_W (64),
        .ADDR_W  (32),
        .TIMEOUT (16)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .pmem_address (pmem_address),
        .pmem_read    (pmem_read),
        .pmem_write   (pmem_write),
        .pmem_wdata   (pmem_wdata),
        .pmem_rdata   (pmem_rdata),
        .pmem_resp    (pmem_resp),
        .err          (err),
        .dram_address (dram_address),
        .dram_read    (dram_read),
        .dram_write   (dram_write),
        .dram_wdata   (dram_wdata),
        .dram_rdata   (dram_rdata),
        .dram_resp    (dram_resp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [255:0] obs,
                         input logic [255:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    logic [63:0]  rb [4];
    logic [63:0]  wb [4];
    logic [255:0] rd_line;
    logic [255:0] wr_line;
    logic [255:0] both_line;
    int           resp_cnt;
    int           resp_at;

    initial begin
        rb[0] = 64'h1111_1111_1111_1111;
        rb[1] = 64'h2222_2222_2222_2222;
        rb[2] = 64'h3333_3333_3333_3333;
        rb[3] = 64'h4444_4444_4444_4444;
        rd_line = {rb[3], rb[2], rb[1], rb[0]};
        wb[0] = 64'h0000_0000_0000_BEEF;
        wb[1] = 64'h1111_0000_1111_0000;
        wb[2] = 64'h2222_0000_2222_0000;
        wb[3] = 64'hDEAD_3333_3333_3333;
        wr_line = {wb[3], wb[2], wb[1], wb[0]};
        both_line = {4{64'hA5A5_5A5A_0F0F_F0F0}};

        rst_n        = 1'b0;
        pmem_address = '0;
        pmem_read    = 1'b0;
        pmem_write   = 1'b0;
        pmem_wdata   = '0;
        dram_rdata   = '0;
        dram_resp    = 1'b0;
        #3;
        check("rst_resp", 256'(pmem_resp), 256'(0));
        check("rst_err", 256'(err), 256'(0));
        check("rst_dread", 256'(dram_read), 256'(0));
        check("rst_dwrite", 256'(dram_write), 256'(0));
        check("rst_daddr", 256'(dram_address), 256'(0));
        check("rst_rdata", pmem_rdata, 256'(0));
        check("rst_wdata", 256'(dram_wdata), 256'(0));
        #10 rst_n = 1'b1;
        tick();

        // Read with back-to-back beats.
        pmem_address = 32'h0000_1234;
        pmem_read    = 1'b1;
        tick();
        check("rd_dread", 256'(dram_read), 256'(1));
        check("rd_daddr", 256'(dram_address), 256'(32'h0000_1220));
        check("rd_dwrite", 256'(dram_write), 256'(0));
        for (int b = 0; b < 4; b++) begin
            dram_resp  = 1'b1;
            dram_rdata = rb[b];
            if (b == 1) pmem_address = 32'hFFFF_FFFF;
            check("rd_noresp", 256'(pmem_resp), 256'(0));
            tick();
        end
        dram_resp  = 1'b0;
        dram_rdata = '0;
        check("rd_resp", 256'(pmem_resp), 256'(1));
        check("rd_line", pmem_rdata, rd_line);
        check("rd_dread_done", 256'(dram_read), 256'(0));
        check("rd_addr_latched", 256'(dram_address), 256'(32'h0000_1220));
        check("rd_err", 256'(err), 256'(0));
        tick();
        pmem_read = 1'b0;
        check("rd_pulse1", 256'(pmem_resp), 256'(0));
        tick();

        // Write with a 3-cycle gap before every beat response.
        pmem_address = 32'h0000_ABCD;
        pmem_wdata   = wr_line;
        pmem_write   = 1'b1;
        tick();
        check("wr_daddr", 256'(dram_address), 256'(32'h0000_ABC0));
        check("wr_dread", 256'(dram_read), 256'(0));
        resp_cnt = 0;
        for (int b = 0; b < 4; b++) begin
            if (b == 1) pmem_wdata = ~wr_line;
            for (int g = 0; g < 3; g++) begin
                check("wr_dwrite", 256'(dram_write), 256'(1));
                check("wr_beat", 256'(dram_wdata), 256'(wb[b]));
                if (pmem_resp) resp_cnt++;
                tick();
            end
            dram_resp = 1'b1;
            tick();
            dram_resp = 1'b0;
            if (b < 3) check("wr_mid_noresp", 256'(pmem_resp), 256'(0));
        end
        check("wr_resp", 256'(pmem_resp), 256'(1));
        check("wr_dwrite_done", 256'(dram_write), 256'(0));
        check("wr_rdata_kept", pmem_rdata, rd_line);
        check("wr_early_resps", 256'(resp_cnt), 256'(0));
        tick();
        pmem_write = 1'b0;
        check("wr_pulse1", 256'(pmem_resp), 256'(0));
        tick();

        // Read and write together: write wins.
        pmem_address = 32'h0000_0040;
        pmem_wdata   = both_line;
        pmem_read    = 1'b1;
        pmem_write   = 1'b1;
        tick();
        check("both_dwrite", 256'(dram_write), 256'(1));
        check("both_dread", 256'(dram_read), 256'(0));
        dram_resp = 1'b1;
        repeat (4) tick();
        dram_resp = 1'b0;
        check("both_resp", 256'(pmem_resp), 256'(1));
        check("both_rdata_kept", pmem_rdata, rd_line);
        tick();
        pmem_read  = 1'b0;
        pmem_write = 1'b0;
        tick();

        // Reset after two read beats.
        pmem_address = 32'h0000_2000;
        pmem_read    = 1'b1;
        tick();
        dram_resp  = 1'b1;
        dram_rdata = 64'hAAAA_AAAA_AAAA_AAAA;
        tick();
        dram_rdata = 64'hBBBB_BBBB_BBBB_BBBB;
        tick();
        dram_resp = 1'b0;
        check("abort_dread_pre", 256'(dram_read), 256'(1));
        #2 rst_n = 1'b0;
        #1;
        check("abort_dread", 256'(dram_read), 256'(0));
        check("abort_resp", 256'(pmem_resp), 256'(0));
        pmem_read = 1'b0;
        #3 rst_n = 1'b1;
        resp_cnt = 0;
        repeat (6) begin
            tick();
            if (pmem_resp) resp_cnt++;
        end
        check("abort_noresp", 256'(resp_cnt), 256'(0));

        // Fresh read after reset.
        pmem_address = 32'h3000_0047;
        pmem_read    = 1'b1;
        tick();
        check("fresh_daddr", 256'(dram_address), 256'(32'h3000_0040));
        for (int b = 0; b < 4; b++) begin
            dram_resp  = 1'b1;
            dram_rdata = 64'(b + 5);
            tick();
        end
        dram_resp = 1'b0;
        check("fresh_resp", 256'(pmem_resp), 256'(1));
        check("fresh_line", pmem_rdata,
              {64'd8, 64'd7, 64'd6, 64'd5});
        tick();
        pmem_read = 1'b0;
        tick();

        // Spurious dram_resp while idle.
        dram_resp  = 1'b1;
        dram_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
        resp_cnt = 0;
        repeat (3) begin
            tick();
            if (pmem_resp || dram_read || dram_write) resp_cnt++;
        end
        dram_resp = 1'b0;
        tick();
        check("spur_idle", 256'(resp_cnt), 256'(0));
        check("spur_rdata", pmem_rdata, {64'd8, 64'd7, 64'd6, 64'd5});

        // Read that never receives a beat.
        pmem_address = 32'h0000_0100;
        pmem_read    = 1'b1;
        resp_at  = 0;
        resp_cnt = 0;
        for (int c = 1; c <= 40; c++) begin
            tick();
            if (pmem_resp) begin
                resp_cnt++;
                if (resp_at == 0) resp_at = c;
                check("wd_err_with_resp", 256'(err), 256'(1));
                pmem_read = 1'b0;
            end else begin
                check("wd_err_idle", 256'(err), 256'(0));
            end
        end
`ifdef CLA_WATCHDOG_EN
        check("wd_resp_cycle", 256'(resp_at), 256'(16));
        check("wd_resp_count", 256'(resp_cnt), 256'(1));
        check("wd_back_idle", 256'(dram_read), 256'(0));
`else
        check("nowd_noresp", 256'(resp_cnt), 256'(0));
        check("nowd_waiting", 256'(dram_read), 256'(1));
`endif
        pmem_read = 1'b0;
        rst_n = 1'b0;
        #4 rst_n = 1'b1;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
